round_robin_arbiter: RTL and testbench

//  Upstream feeder of the selector-delay buffer stage. Drains two show-ahead input FIFOs
//  (queue 0 and queue 1) into one data stream using bursted round-robin arbitration.

---
 rtl/round_robin_arbiter.sv | 131 +++++++++++++
 tb/tb_round_robin_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// Bursted round-robin drain of two show-ahead FIFOs into one registered stream.
// Optional saturating pop counters are enabled by defining ARB_COUNTERS_EN.
module round_robin_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  fifo0_empty,
  input  logic                  fifo1_empty,
  input  logic [DATA_WIDTH-1:0] fifo0_data,
  input  logic [DATA_WIDTH-1:0] fifo1_data,
  input  logic                  dest_almost_full,
  output logic                  pop0,
  output logic                  pop1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  selector
`ifdef ARB_COUNTERS_EN
  ,
  output logic [7:0]            count0,
  output logic [7:0]            count1
`endif
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t           state, state_nxt;
  logic             ptr, ptr_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic             active, q, empty_q, empty_o;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = burst_cnt;
    pop0      = 1'b0;
    pop1      = 1'b0;
    active    = 1'b0;
    q         = 1'b0;
    empty_q   = 1'b1;
    empty_o   = 1'b1;
    // Pops are gated by reset so the strobes stay low while reset is held.
    if (reset_L && !dest_almost_full) begin
      unique case (state)
        IDLE: begin
          if (!fifo0_empty || !fifo1_empty) begin
            q      = fifo0_empty ? 1'b1 : (fifo1_empty ? 1'b0 : ptr);
            active = 1'b1;
          end
        end
        SERVE0: begin
          q      = 1'b0;
          active = 1'b1;
        end
        SERVE1: begin
          q      = 1'b1;
          active = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
      empty_q = q ? fifo1_empty : fifo0_empty;
      empty_o = q ? fifo0_empty : fifo1_empty;
      if (active) begin
        if (!empty_q) begin
          pop0      = ~q;
          pop1      = q;
          state_nxt = q ? SERVE1 : SERVE0;
          if (burst_cnt == LAST) begin
            cnt_nxt = '0;
            if (!empty_o) begin
              state_nxt = q ? SERVE0 : SERVE1;
              ptr_nxt   = ~q;
            end
          end else begin
            cnt_nxt = burst_cnt + CNT_W'(1);
          end
        end else if (!empty_o) begin
          // Served queue drained: spend one cycle switching to the other.
          state_nxt = q ? SERVE0 : SERVE1;
          ptr_nxt   = ~q;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
          ptr_nxt   = ~q;
          cnt_nxt   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      burst_cnt <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      selector  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= cnt_nxt;
      valid_out <= pop0 | pop1;
      if (pop0 | pop1) begin
        data_out <= pop1 ? fifo1_data : fifo0_data;
        selector <= pop1;
      end
    end
  end

`ifdef ARB_COUNTERS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count0 <= 8'd0;
      count1 <= 8'd0;
    end else begin
      if (pop0) count0 <= sat_inc(count0);
      if (pop1) count1 <= sat_inc(count1);
    end
  end
`endif

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: FIFO models, a queue-level reference model,
// a vector table for the both-queues burst pattern and randomized traffic.
module tb_round_robin_arbiter;

  localparam int DATA_WIDTH = 6;
  localparam int BURST      = 4;

  logic                  clk = 1'b0;
  logic                  clk_run = 1'b0;
  logic                  reset_L;
  logic                  fifo0_empty, fifo1_empty;
  logic [DATA_WIDTH-1:0] fifo0_data, fifo1_data;
  logic                  dest_almost_full;
  logic                  pop0, pop1;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out, selector;
`ifdef ARB_COUNTERS_EN
  logic [7:0]            count0, count1;
`endif

  round_robin_arbiter #(.DATA_WIDTH(DATA_WIDTH), .BURST(BURST)) dut (
    .clk(clk),
    .reset_L(reset_L),
    .fifo0_empty(fifo0_empty),
    .fifo1_empty(fifo1_empty),
    .fifo0_data(fifo0_data),
    .fifo1_data(fifo1_data),
    .dest_almost_full(dest_almost_full),
    .pop0(pop0),
    .pop1(pop1),
    .data_out(data_out),
    .valid_out(valid_out),
    .selector(selector)
`ifdef ARB_COUNTERS_EN
    ,
    .count0(count0),
    .count1(count1)
`endif
  );

  always #5 if (clk_run) clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_WIDTH-1:0] q0[$];
  logic [DATA_WIDTH-1:0] q1[$];

  // Reference model: which queue is being served (-1 none), words taken in
  // the current burst, preferred queue, expected registered outputs.
  int                    cur, taken, pref;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  exp_valid, exp_sel;
  int                    exp_c0, exp_c1;
  logic                  obs_pop0, obs_pop1;

  typedef struct {
    logic daf;
    logic pop0;
    logic pop1;
    logic valid;
    logic sel;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_heads();
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    fifo0_data  = fifo0_empty ? '0 : q0[0];
    fifo1_data  = fifo1_empty ? '0 : q1[0];
  endtask

  task automatic model_reset();
    cur = -1; taken = 0; pref = 0;
    exp_data = '0; exp_valid = 1'b0; exp_sel = 1'b0;
    exp_c0 = 0; exp_c1 = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " valid_out"}, valid_out, exp_valid);
    check({tag, " data_out"}, data_out, exp_data);
    check({tag, " selector"}, selector, exp_sel);
`ifdef ARB_COUNTERS_EN
    check({tag, " count0"}, count0, exp_c0);
    check({tag, " count1"}, count1, exp_c1);
`endif
  endtask

  // One clock cycle: drive inputs, check pops, clock, check registered outputs.
  task automatic step(input logic daf);
    logic m0, m1, e0, e1, eo;
    dest_almost_full = daf;
    drive_heads();
    #1;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    m0 = 1'b0; m1 = 1'b0;
    if (!daf) begin
      if (cur < 0) begin
        if (!e0 && !e1) begin
          if (pref == 0) m0 = 1'b1; else m1 = 1'b1;
        end else if (!e0) m0 = 1'b1;
        else if (!e1) m1 = 1'b1;
      end else if (cur == 0 && !e0) m0 = 1'b1;
      else if (cur == 1 && !e1) m1 = 1'b1;
    end
    obs_pop0 = pop0;
    obs_pop1 = pop1;
    check("pop0", pop0, m0);
    check("pop1", pop1, m1);
    @(posedge clk);
    if (m0) begin
      exp_data = q0.pop_front(); exp_sel = 1'b0; exp_valid = 1'b1;
      if (exp_c0 < 255) exp_c0++;
    end else if (m1) begin
      exp_data = q1.pop_front(); exp_sel = 1'b1; exp_valid = 1'b1;
      if (exp_c1 < 255) exp_c1++;
    end else begin
      exp_valid = 1'b0;
    end
    if (!daf) begin
      if (cur < 0 && (m0 || m1)) begin
        cur = m1 ? 1 : 0;
        taken = 0;
      end
      if (cur >= 0) begin
        eo = (cur == 0) ? e1 : e0;
        if (m0 || m1) begin
          taken++;
          if (taken == BURST) begin
            taken = 0;
            if (!eo) begin cur = 1 - cur; pref = cur; end
          end
        end else if (!eo) begin
          cur = 1 - cur; pref = cur; taken = 0;
        end else begin
          pref = 1 - cur; cur = -1; taken = 0;
        end
      end
    end
    #1;
    check_outputs("step");
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    model_reset();
    check("rst pop0", pop0, 1'b0);
    check("rst pop1", pop1, 1'b0);
    check_outputs("rst");
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 4; i < 8; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with the clock stopped and queue 0 holding data.
    model_reset();
    dest_almost_full = 1'b0;
    reset_L = 1'b0;
    q0.push_back(6'h15);
    drive_heads();
    #3;
    check("init pop0", pop0, 1'b0);
    check("init pop1", pop1, 1'b0);
    check_outputs("init");
    q0.delete();
    drive_heads();
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);

    // Only queue 0 holds three words.
    q0.push_back(6'h11); q0.push_back(6'h12); q0.push_back(6'h13);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check($sformatf("q0only data %0d", i), data_out, 6'h11 + i);
      check($sformatf("q0only sel %0d", i), selector, 1'b0);
    end
    step(1'b0);
    check("q0only tail valid", valid_out, 1'b0);

    // Both queues hold six words; table gives the burst pattern.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(6'h20 + 6'(i));
      q1.push_back(6'h30 + 6'(i));
    end
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].daf);
      check($sformatf("tbl pop0 %0d", i), obs_pop0, tbl[i].pop0);
      check($sformatf("tbl pop1 %0d", i), obs_pop1, tbl[i].pop1);
      check($sformatf("tbl valid %0d", i), valid_out, tbl[i].valid);
      check($sformatf("tbl sel %0d", i), selector, tbl[i].sel);
    end

    // Backpressure for five cycles inside the second burst.
    for (int i = 0; i < 6; i++) begin
      q0.push_back(6'h01 + 6'(i));
      q1.push_back(6'h09 + 6'(i));
    end
    for (int i = 0; i < 22; i++) begin
      step(i >= 5 && i < 10);
      if (i >= 5 && i < 10) begin
        check($sformatf("daf pop %0d", i), obs_pop0 | obs_pop1, 1'b0);
        check($sformatf("daf valid %0d", i), valid_out, 1'b0);
      end
    end

    // Queue 1 runs dry after two words while queue 0 still has data.
    do_reset();
    for (int i = 0; i < 5; i++) q0.push_back(6'h38 + 6'(i));
    q1.push_back(6'h2A); q1.push_back(6'h2B);
    for (int i = 0; i < 9; i++) begin
      step(1'b0);
      if (i == 6) check("q1dry gap valid", valid_out, 1'b0);
      if (i == 7) begin
        check("q1dry resume sel", selector, 1'b0);
        check("q1dry resume data", data_out, 6'h3C);
      end
    end

    // Randomized traffic with backpressure and one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if ($urandom_range(0, 99) < 40 && q0.size() < 8) q0.push_back(DATA_WIDTH'($urandom));
      if ($urandom_range(0, 99) < 35 && q1.size() < 8) q1.push_back(DATA_WIDTH'($urandom));
      step($urandom_range(0, 3) == 0);
    end

    // Long run from queue 1 only.
    do_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 300; i++) q1.push_back(DATA_WIDTH'(i));
    for (int i = 0; i < 302; i++) step(1'b0);
`ifdef ARB_COUNTERS_EN
    check("sat count1", count1, 8'd255);
    check("sat count0", count0, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
